apb2reg_bridge: RTL
===================

APB2REG_BRIDGE -- requirements
Module: apb2reg_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 24: width of paddr and reg_addr.
REQ-002 Parameter ADDR_LIMIT, default 'h100: first out-of-range byte address.
REQ-003 reg_clk  input  1  single clock; all logic on rising edge.
REQ-004 reg_rst  input  1  reset, synchronous and active-high.
REQ-005 psel  input  1  APB select.
REQ-006 penable  input  1  APB access phase.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  ADDR_WIDTH  APB byte address.
REQ-009 pwdata  input  32  APB write data.
REQ-010 pstrb  input  4  APB byte strobes.
REQ-011 pready  output  1  transfer complete.
REQ-012 prdata  output  32  read data.
REQ-013 pslverr  output  1  transfer error; valid only while pready=1.
REQ-014 reg_wr  output  1  one-cycle write strobe to the downstream register block.
REQ-015 reg_rd  output  1  one-cycle read strobe to the downstream register block.
REQ-016 reg_we  output  4  byte enables, valid with reg_wr.
REQ-017 reg_addr  output  ADDR_WIDTH  register address.
REQ-018 reg_wdat  output  32  write data.
REQ-019 reg_rdat  input  32  read data, registered by the register block, valid the cycle after reg_rd.

Function
REQ-020 FSM states: IDLE, WR, RD, RDWAIT, RESP, ERR; all outputs are registered.
REQ-021 IDLE: on psel=1 & penable=0 (setup), latch paddr, pwdata, pstrb and pwrite into reg_addr/reg_wdat/reg_we/direction, then go to ERR if the address is illegal, else WR (write) or RD (read).
REQ-022 Illegal address: paddr[1:0]!=0, or paddr>=ADDR_LIMIT.
REQ-023 WR: reg_wr=1 and pready=1 for exactly this cycle, pslverr=0, then IDLE; write latency is setup+1 cycle, i.e. 2 APB cycles with zero wait states.
REQ-024 RD: reg_rd=1 for exactly this cycle, reg_we=0, pready=0, then RDWAIT.
REQ-025 RDWAIT: capture reg_rdat into the prdata register, pready=0, then RESP.
REQ-026 RESP: pready=1, pslverr=0, prdata holds the captured value, then IDLE; read latency is setup+3 cycles (2 wait states).
REQ-027 ERR: pready=1, pslverr=1, prdata=0, reg_wr=reg_rd=0 (no downstream access), then IDLE.
REQ-028 Outside WR/RD, reg_wr=0 and reg_rd=0; the strobes never assert for two consecutive cycles.
REQ-029 Outside RESP, prdata=0; outside WR/RESP/ERR, pready=0; outside ERR, pslverr=0.
REQ-030 reg_addr, reg_wdat and reg_we hold their values until the next setup latch; on reads, reg_we is forced to 0 at latch.
REQ-031 A write with pstrb=0 still issues reg_wr, with reg_we=0.
REQ-032 If psel=0 in RD, RDWAIT or RESP (master abort), the FSM returns to IDLE next cycle with pready=0; a strobe already issued is not retracted.
REQ-033 Back-to-back: a setup phase in the cycle after pready=1 is accepted (IDLE is re-entered that cycle), so no idle cycle is needed between transfers.
REQ-034 penable=1 seen in IDLE without a prior setup is ignored (stay IDLE, no strobe).

Reset
REQ-035 While reg_rst=1 at a rising edge, the next state is IDLE and all outputs are 0 (pready, pslverr, prdata, reg_wr, reg_rd, reg_we, reg_addr, reg_wdat).
REQ-036 Reset asserted mid-transfer aborts it without a completing pready; a strobe in the reset cycle is suppressed.

Verification
REQ-037 Write paddr='h8, pwdata='hA5A5_0F0F, pstrb='b0011 -> one reg_wr cycle with reg_addr='h8 and reg_we='b0011; pready=1 in the same cycle; pslverr=0.
REQ-038 Read paddr='h0 with the model returning 'h0000_0102 a cycle after reg_rd -> one reg_rd pulse; pready=1 three cycles after setup with prdata='h0000_0102.
REQ-039 Write paddr='h6 (unaligned), then read paddr='h100 (out of range) -> no strobes; each completes one cycle after setup with pready=1, pslverr=1, prdata=0.
REQ-040 Back-to-back write 'h0, read 'h8, write 'h8 with no idle cycles -> three strobes in order, correct data on each; total 2+4+2 cycles.
REQ-041 reg_rst=1 in the RDWAIT cycle of a read -> next cycle all outputs are 0, no pready; a following write to 'h0 completes normally.
REQ-042 Master drops psel in the RD cycle -> IDLE next cycle, no pready pulse, prdata stays 0.

Source files
------------

// File: rtl/apb2reg_bridge.sv
// APB slave to simple register-strobe bridge.
// Every setup phase is latched into the reg_* outputs. Legal writes get a
// one-cycle reg_wr strobe together with pready. Legal reads get a reg_rd
// strobe, one cycle to capture reg_rdat, then the response cycle. Illegal
// addresses complete with pslverr and make no downstream access.
module apb2reg_bridge #(
    parameter int ADDR_WIDTH = 24,
    parameter int ADDR_LIMIT = 'h100
) (
    input  logic                  reg_clk,
    input  logic                  reg_rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    input  logic [3:0]            pstrb,
    output logic                  pready,
    output logic [31:0]           prdata,
    output logic                  pslverr,
    output logic                  reg_wr,
    output logic                  reg_rd,
    output logic [3:0]            reg_we,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [31:0]           reg_wdat,
    input  logic [31:0]           reg_rdat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDWAIT,
        S_RESP,
        S_ERR
    } state_e;

    // One extra bit so a limit equal to 2**ADDR_WIDTH still compares correctly
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(ADDR_LIMIT);

    state_e                  state_q, state_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [31:0]             prdata_q, prdata_d;
    logic                    reg_wr_q, reg_wr_d;
    logic                    reg_rd_q, reg_rd_d;
    logic [3:0]              reg_we_q, reg_we_d;
    logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
    logic [31:0]             reg_wdat_q, reg_wdat_d;

    logic setup;
    logic illegal;

    // A setup phase is only recognised while idle; a stray access phase is ignored
    assign setup   = (state_q == S_IDLE) && psel && !penable;
    assign illegal = (paddr[1:0] != 2'b00) || ({1'b0, paddr} >= LIMIT);

    // State and output registers; reset clears everything, squashing any pending strobe
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            state_q    <= S_IDLE;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            reg_wr_q   <= 1'b0;
            reg_rd_q   <= 1'b0;
            reg_we_q   <= '0;
            reg_addr_q <= '0;
            reg_wdat_q <= '0;
        end else begin
            state_q    <= state_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            reg_wr_q   <= reg_wr_d;
            reg_rd_q   <= reg_rd_d;
            reg_we_q   <= reg_we_d;
            reg_addr_q <= reg_addr_d;
            reg_wdat_q <= reg_wdat_d;
        end
    end

    // Next-state: read path may be abandoned by the master dropping psel
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (setup) begin
                    if (illegal)     state_d = S_ERR;
                    else if (pwrite) state_d = S_WR;
                    else             state_d = S_RD;
                end
            end
            S_RD:     state_d = psel ? S_RDWAIT : S_IDLE;
            S_RDWAIT: state_d = psel ? S_RESP   : S_IDLE;
            S_WR, S_RESP, S_ERR: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they are registered with it
    always_comb begin
        pready_d   = (state_d == S_WR) || (state_d == S_RESP) || (state_d == S_ERR);
        pslverr_d  = (state_d == S_ERR);
        reg_wr_d   = (state_d == S_WR);
        reg_rd_d   = (state_d == S_RD);
        // RESP is only entered from RDWAIT, when reg_rdat carries the read result
        prdata_d   = (state_d == S_RESP) ? reg_rdat : 32'h0;
        reg_addr_d = reg_addr_q;
        reg_wdat_d = reg_wdat_q;
        reg_we_d   = reg_we_q;
        if (setup) begin
            reg_addr_d = paddr;
            reg_wdat_d = pwdata;
            reg_we_d   = pwrite ? pstrb : 4'b0000;
        end
    end

    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign prdata   = prdata_q;
    assign reg_wr   = reg_wr_q;
    assign reg_rd   = reg_rd_q;
    assign reg_we   = reg_we_q;
    assign reg_addr = reg_addr_q;
    assign reg_wdat = reg_wdat_q;

endmodule
